imm_extend_seq: RTL and testbench

Parametrised, sequential successor to the combinational immediate extender. It decodes the ARM immediate fields of Instr[23:0] into a WIDTH-bit operand and adds the data-processing rotated-immediate mode (imm8 ROR 2*rot4) together with its shifter carry-out. It sits between the decode stage and the multicycle datapath's ALU/address path. Operands enter and leave through a valid/ready handshake, so the rotate can be iterative (2 bits per cycle) or single-step.

---
 rtl/imm_extend_seq.sv | 132 +++++++++++++
 tb/tb_imm_extend_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_seq.sv
// Sequential ARM immediate extender: decodes Instr[23:0] into a WIDTH-bit operand,
// including the rotated-immediate mode (imm8 ROR 2*rot4) and its shifter carry-out.
module imm_extend_seq #(
  parameter int WIDTH    = 32,
  parameter bit FAST_ROT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [23:0]      Instr,
  input  logic [1:0]       ImmSrc,
  input  logic             CarryIn,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ExtImm,
  output logic             ShCarry,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready. Only one
  // request is ever in flight, so in_ready is low from acceptance until the
  // result has been taken.

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ROTATE = 2'b01,
    S_DONE   = 2'b10
  } state_t;

  localparam logic [1:0] SRC_ROT   = 2'b00;
  localparam logic [1:0] SRC_IMM24 = 2'b01;
  localparam logic [1:0] SRC_IMM12 = 2'b10;
  localparam logic [1:0] SRC_BR    = 2'b11;

  state_t           r_state;
  logic [WIDTH-1:0] r_ext;
  logic             r_carry;
  logic [3:0]       r_count;

  logic [WIDTH-1:0]  w_imm8;
  logic [WIDTH-1:0]  w_imm12;
  logic [WIDTH-1:0]  w_imm24;
  logic signed [25:0] w_br26;
  logic [WIDTH-1:0]  w_br;
  logic [3:0]        w_rot;
  logic [WIDTH-1:0]  w_fast_rot;
  logic [WIDTH-1:0]  w_step;

  function automatic logic [WIDTH-1:0] ror2(input logic [WIDTH-1:0] v);
    return {v[1:0], v[WIDTH-1:2]};
  endfunction

  assign w_rot   = Instr[11:8];
  assign w_imm8  = {{(WIDTH-8){1'b0}}, Instr[7:0]};
  assign w_imm12 = {{(WIDTH-12){1'b0}}, Instr[11:0]};
  assign w_imm24 = {{(WIDTH-24){1'b0}}, Instr[23:0]};
  assign w_br26  = {Instr[23:0], 2'b00};
  assign w_br    = WIDTH'(w_br26);
  assign w_step  = ror2(r_ext);

  // Repeated 2-bit steps keep the rotate modulo WIDTH even when 2*rot >= WIDTH.
  always_comb begin
    w_fast_rot = w_imm8;
    for (int i = 0; i < 15; i++) begin
      if (4'(i) < w_rot) begin
        w_fast_rot = ror2(w_fast_rot);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state <= S_IDLE;
      r_ext   <= '0;
      r_carry <= 1'b0;
      r_count <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= S_DONE;
            r_carry <= CarryIn;
            case (ImmSrc)
              SRC_ROT: begin
                if (w_rot == 4'd0) begin
                  r_ext <= w_imm8;
                end else if (FAST_ROT) begin
                  r_ext   <= w_fast_rot;
                  r_carry <= w_fast_rot[WIDTH-1];
                end else begin
                  r_ext   <= w_imm8;
                  r_count <= w_rot;
                  r_state <= S_ROTATE;
                end
              end
              SRC_IMM24: r_ext <= w_imm24;
              SRC_IMM12: r_ext <= w_imm12;
              SRC_BR:    r_ext <= w_br;
              default:   r_ext <= w_imm8;
            endcase
          end
        end
        S_ROTATE: begin
          r_ext   <= w_step;
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            r_carry <= w_step[WIDTH-1];
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_ROTATE) || (r_state == S_DONE);
  assign ExtImm    = r_ext;
  assign ShCarry   = r_carry;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_imm_extend_seq.sv
// Bench for imm_extend_seq: an iterative and a single-step instance share stimulus;
// each has its own expected queue, drained by a monitor on completed output handshakes.
module tb_imm_extend_seq;
  localparam int W  = 32;
  localparam int QW = W + 1 + 8;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, carry_in, in_valid, out_ready;
  logic [23:0] instr;
  logic [1:0]  imm_src;

  logic [W-1:0] ext0, ext1;
  logic         sh0, sh1, ir0, ir1, ov0, ov1, bz0, bz1;
  logic [1:0]   st0, st1;

  imm_extend_seq #(.WIDTH(W), .FAST_ROT(1'b0)) u_slow (
    .clk(clk), .reset(reset), .flush(flush), .Instr(instr), .ImmSrc(imm_src),
    .CarryIn(carry_in), .in_valid(in_valid), .in_ready(ir0), .out_valid(ov0),
    .out_ready(out_ready), .ExtImm(ext0), .ShCarry(sh0), .busy(bz0), .dbg_state(st0)
  );

  imm_extend_seq #(.WIDTH(W), .FAST_ROT(1'b1)) u_fast (
    .clk(clk), .reset(reset), .flush(flush), .Instr(instr), .ImmSrc(imm_src),
    .CarryIn(carry_in), .in_valid(in_valid), .in_ready(ir1), .out_valid(ov1),
    .out_ready(out_ready), .ExtImm(ext1), .ShCarry(sh1), .busy(bz1), .dbg_state(st1)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state: {latency[7:0], ShCarry, ExtImm}
  logic [QW-1:0] exp_q0[$];
  logic [QW-1:0] exp_q1[$];
  int   acc_cyc[2];
  int   lat_meas[2];
  logic prev_ov[2];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon_step(input int d, input logic v_ov, input logic v_ir,
                          input logic v_sh, input logic [W-1:0] v_ext);
    logic [QW-1:0] e;
    logic          empty;
    if (in_valid && v_ir) acc_cyc[d] = cyc;
    if (v_ov && !prev_ov[d]) lat_meas[d] = cyc - acc_cyc[d];
    prev_ov[d] = v_ov;
    if (v_ov && out_ready) begin
      empty = (d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
      if (empty) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output dut%0d: ExtImm=0x%0h with no request pending", d, v_ext);
      end else begin
        if (d == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        chk($sformatf("dut%0d ExtImm", d), v_ext, e[W-1:0]);
        chk($sformatf("dut%0d ShCarry", d), W'(v_sh), W'(e[W]));
        chk($sformatf("dut%0d latency", d), W'(lat_meas[d]), W'(e[QW-1:W+1]));
      end
    end
  endtask

  // monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    mon_step(0, ov0, ir0, sh0, ext0);
    mon_step(1, ov1, ir1, sh1, ext1);
  end

  // driver tasks: called and return at posedge + #1
  task automatic issue(input logic [1:0] src, input logic [23:0] ins, input logic cin,
                       input logic [W-1:0] e_ext, input logic e_c, input int lat_slow,
                       input bit expect_out);
    int n = 0;
    while (!(ir0 && ir1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready=%0b/%0b required 1/1", ir0, ir1);
      return;
    end
    if (expect_out) begin
      exp_q0.push_back({8'(lat_slow), e_c, e_ext});
      exp_q1.push_back({8'd1, e_c, e_ext});
    end
    imm_src  = src;
    instr    = ins;
    carry_in = cin;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(exp_q0.size() == 0 && exp_q1.size() == 0 && ir0 && ir1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d/%0d required 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    prev_ov[0] = 1'b0; prev_ov[1] = 1'b0;
    acc_cyc[0] = 0;    acc_cyc[1] = 0;
    lat_meas[0] = 0;   lat_meas[1] = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; imm_src = 2'b00; carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset ExtImm slow", ext0, '0);
    chk("reset ExtImm fast", ext1, '0);
    chk("reset ShCarry slow", W'(sh0), '0);
    chk("reset ShCarry fast", W'(sh1), '0);
    chk("reset out_valid", W'({ov1, ov0}), '0);
    chk("reset in_ready", W'({ir1, ir0}), W'(2'b11));
    chk("reset busy", W'({bz1, bz0}), '0);

    // directed vectors: src, Instr, CarryIn, ExtImm, ShCarry, slow latency
    issue(2'b00, 24'h5A14FF, 1'b0, 32'hFF000000, 1'b1, 5, 1);
    issue(2'b00, 24'h0001FF, 1'b0, 32'hC000003F, 1'b1, 2, 1);
    issue(2'b00, 24'h0000AB, 1'b0, 32'h000000AB, 1'b0, 1, 1);
    issue(2'b00, 24'h000000, 1'b1, 32'h00000000, 1'b1, 1, 1);
    issue(2'b00, 24'h000103, 1'b0, 32'hC0000000, 1'b1, 2, 1);
    issue(2'b00, 24'h000F01, 1'b1, 32'h00000004, 1'b0, 16, 1);
    issue(2'b00, 24'h000C80, 1'b1, 32'h00008000, 1'b0, 13, 1);
    issue(2'b11, 24'hFFFFFE, 1'b1, 32'hFFFFFFF8, 1'b1, 1, 1);
    issue(2'b11, 24'h000010, 1'b0, 32'h00000040, 1'b0, 1, 1);
    issue(2'b10, 24'hABC123, 1'b0, 32'h00000123, 1'b0, 1, 1);
    issue(2'b01, 24'h800001, 1'b1, 32'h00800001, 1'b1, 1, 1);
    wait_idle();

    // backpressure: hold DONE for 4 cycles, with a stray request that must be ignored
    out_ready = 1'b0;
    issue(2'b01, 24'h123456, 1'b0, 32'h00123456, 1'b0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hold%0d ExtImm slow", i), ext0, 32'h00123456);
      chk($sformatf("hold%0d ExtImm fast", i), ext1, 32'h00123456);
      chk($sformatf("hold%0d in_ready", i), W'({ir1, ir0}), '0);
      chk($sformatf("hold%0d out_valid", i), W'({ov1, ov0}), W'(2'b11));
      chk($sformatf("hold%0d busy", i), W'({bz1, bz0}), W'(2'b11));
      if (i == 0) begin
        in_valid = 1'b1; imm_src = 2'b01; instr = 24'hFFFFFF;
      end
      if (i == 1) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release out_valid", W'({ov1, ov0}), '0);
    chk("release in_ready", W'({ir1, ir0}), W'(2'b11));
    wait_idle();

    // flush in the second ROTATE cycle of a rot=6 request
    out_ready = 1'b0;
    issue(2'b00, 24'h000680, 1'b0, '0, 1'b0, 7, 0);
    @(posedge clk); #1;
    chk("rotate busy", W'(bz0), W'(1'b1));
    chk("rotate in_ready", W'(ir0), '0);
    chk("rotate out_valid", W'(ov0), '0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush ExtImm slow", ext0, '0);
    chk("flush ExtImm fast", ext1, '0);
    chk("flush ShCarry", W'({sh1, sh0}), '0);
    chk("flush out_valid", W'({ov1, ov0}), '0);
    chk("flush in_ready", W'({ir1, ir0}), W'(2'b11));
    chk("flush busy", W'({bz1, bz0}), '0);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ov0 || ov1) seen = 1'b1;
    end
    chk("flush no output", W'(seen), '0);
    issue(2'b00, 24'h000680, 1'b0, 32'h08000000, 1'b0, 7, 1);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
